// File: rtl/alu_definitions.sv
// ALU operation classes, status flag type and RV32I R-type encoding constants.
package alu_definitions;

  typedef enum logic [1:0] {
    TYPE_R     = 2'd0,
    TYPE_I     = 2'd1,
    TYPE_LOAD  = 2'd2,
    TYPE_STORE = 2'd3
  } aluOp_t;

  typedef logic flag_t;

  localparam logic [6:0] OPCODE_R = 7'b0110011;
  localparam logic [6:0] F7_BASE  = 7'h00;
  localparam logic [6:0] F7_ALT   = 7'h20;

endpackage

// File: rtl/definitions.sv
// Sequencer state encoding.
package definitions;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    WRITEBACK = 3'd3,
    REJECT    = 3'd4
  } seqState_t;

endpackage

// File: rtl/reg_names.sv
// Register-file naming shared by the datapath blocks.
package reg_names;

  typedef logic [4:0] regName_t;

  localparam regName_t X0 = 5'd0;

endpackage

// File: rtl/rtype_legal_check.sv
// Combinational legality check for an RV32I R-type word: opcode plus the
// funct7/funct3 pairs the ALU implements (funct7 alternate only for sub/sra).
module rtype_legal_check
  import alu_definitions::*;
(
  input  logic [31:0] instr,
  output logic        legal
);

  logic [6:0] opcode_s;
  logic [6:0] funct7_s;
  logic [2:0] funct3_s;
  logic       unused_s;

  assign opcode_s = instr[6:0];
  assign funct7_s = instr[31:25];
  assign funct3_s = instr[14:12];
  assign unused_s = ^{instr[24:15], instr[11:7]};

  // Legal only when every encoding field belongs to the supported set.
  always_comb begin
    legal = 1'b0;
    if (opcode_s == OPCODE_R) begin
      if (funct7_s == F7_BASE) begin
        legal = 1'b1;
      end else if (funct7_s == F7_ALT) begin
        legal = (funct3_s == 3'd0) || (funct3_s == 3'd5);
      end else begin
        legal = 1'b0;
      end
    end else begin
      legal = 1'b0;
    end
  end

endmodule

// File: rtl/rtype_sequencer.sv
// Multi-cycle R-type sequencer: accepts one instruction per handshake and steps
// the register file / ALU through decode, execute and write-back.
module rtype_sequencer
  import definitions::*;
  import alu_definitions::*;
  import reg_names::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic                   instr_valid,
  input  logic [31:0]            instr,
  output logic                   instr_ready,
  output regName_t               rs1,
  output regName_t               rs2,
  output regName_t               rd,
  output logic                   wen,
  output aluOp_t                 aluOp,
  output logic [6:0]             funct7,
  output logic [2:0]             funct3,
  input  flag_t                  error_in,
  output logic                   done,
  output logic                   illegal,
  output logic [COUNT_WIDTH-1:0] retired_count
);

  seqState_t              state_r;
  seqState_t              state_next_s;
  logic                   legal_s;
  logic                   accept_s;
  regName_t               rs1_r;
  regName_t               rs2_r;
  regName_t               rd_r;
  logic [6:0]             funct7_r;
  logic [2:0]             funct3_r;
  logic [COUNT_WIDTH-1:0] count_r;

  rtype_legal_check u_legal_check (
    .instr (instr),
    .legal (legal_s)
  );

  assign accept_s = instr_valid && (state_r == IDLE);

  // State register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = legal_s ? DECODE : REJECT;
        end else begin
          state_next_s = IDLE;
        end
      end
      DECODE:    state_next_s = EXECUTE;
      EXECUTE: begin
        if (error_in) begin
          state_next_s = REJECT;
        end else begin
          state_next_s = WRITEBACK;
        end
      end
      WRITEBACK: state_next_s = IDLE;
      REJECT:    state_next_s = IDLE;
      default:   state_next_s = IDLE;
    endcase
  end

  // Instruction fields are only replaced by a legal word; rejected words leave them as they were.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rs1_r    <= X0;
      rs2_r    <= X0;
      rd_r     <= X0;
      funct7_r <= 7'd0;
      funct3_r <= 3'd0;
    end else if (accept_s && legal_s) begin
      rs1_r    <= instr[19:15];
      rs2_r    <= instr[24:20];
      rd_r     <= instr[11:7];
      funct7_r <= instr[31:25];
      funct3_r <= instr[14:12];
    end
  end

  // Retired-instruction counter, free-running wrap.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      count_r <= {COUNT_WIDTH{1'b0}};
    end else if (state_r == WRITEBACK) begin
      count_r <= count_r + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Moore output decode; wen falls with reset because the state register does.
  always_comb begin
    instr_ready = 1'b0;
    wen         = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state_r)
      IDLE:      instr_ready = 1'b1;
      DECODE:    wen = 1'b0;
      EXECUTE:   wen = 1'b0;
      WRITEBACK: begin
        wen  = (rd_r != X0);
        done = 1'b1;
      end
      REJECT:    illegal = 1'b1;
      default:   instr_ready = 1'b0;
    endcase
  end

  assign rs1           = rs1_r;
  assign rs2           = rs2_r;
  assign rd            = rd_r;
  assign funct7        = funct7_r;
  assign funct3        = funct3_r;
  assign aluOp         = TYPE_R;
  assign retired_count = count_r;

endmodule

// File: tb/tb_rtype_sequencer.sv
// Scoreboard bench for rtype_sequencer with a behavioural register file and ALU.
module tb_rtype_sequencer;
  import alu_definitions::*;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rstN = 1'b1;
  logic          instr_valid = 1'b0;
  logic [31:0]   instr = 32'd0;
  logic          instr_ready;
  logic [4:0]    rs1, rs2, rd;
  logic          wen;
  aluOp_t        aluOp;
  logic [6:0]    funct7;
  logic [2:0]    funct3;
  logic          error_in;
  logic          done;
  logic          illegal;
  logic [CW-1:0] retired_count;

  logic [31:0] regs [32];
  logic [31:0] ra, rb, alu_out;
  logic        pl_en = 1'b0;
  logic [4:0]  pl_addr = 5'd0;
  logic [31:0] pl_data = 32'd0;
  logic        err_inj = 1'b0;
  int          cyc = 0;

  typedef struct {
    bit          is_done;
    int          lat;
    logic [4:0]  rd;
    logic [31:0] value;
    logic [31:0] count;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  exp_t        pe;
  bit          mon_pend = 1'b0;
  logic [CW-1:0] exp_count = '0;
  int          checks = 0;
  int          errors = 0;

  rtype_sequencer #(.COUNT_WIDTH(CW)) dut (
    .clk           (clk),
    .rstN          (rstN),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_ready   (instr_ready),
    .rs1           (rs1),
    .rs2           (rs2),
    .rd            (rd),
    .wen           (wen),
    .aluOp         (aluOp),
    .funct7        (funct7),
    .funct3        (funct3),
    .error_in      (error_in),
    .done          (done),
    .illegal       (illegal),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [6:0] f7, input logic [2:0] f3);
    case (f3)
      3'd0: alu_f = f7[5] ? a - b : a + b;
      3'd1: alu_f = a << b[4:0];
      3'd2: alu_f = {31'd0, $signed(a) < $signed(b)};
      3'd3: alu_f = {31'd0, a < b};
      3'd4: alu_f = a ^ b;
      3'd5: alu_f = f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: alu_f = a | b;
      default: alu_f = a & b;
    endcase
  endfunction

  assign ra       = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rb       = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
  assign alu_out  = alu_f(ra, rb, funct7, funct3);
  assign error_in = err_inj;

  always @(posedge clk) begin
    if (pl_en) regs[pl_addr] <= pl_data;
    else if (wen) regs[rd] <= alu_out;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Offer a word (called at a negedge), push its expectation, return after acceptance.
  task automatic send(input logic [31:0] w, input bit ok, input logic [4:0] rd_e,
                      input logic [31:0] val_e, input int lat, input bit keep, output int acc);
    exp_t e;
    int n = 0;
    instr = w;
    instr_valid = 1'b1;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    acc = cyc + 1;
    if (!instr_ready) begin
      check_eq("accept_timeout", 32'(instr_ready), 32'd1);
    end else begin
      if (ok) exp_count = exp_count + 1'b1;
      e.is_done = ok; e.lat = lat; e.rd = rd_e; e.value = val_e;
      e.count = 32'(exp_count); e.acc = acc;
      sb.push_back(e);
    end
    @(negedge clk);
    if (!keep) instr_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || mon_pend) && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check_eq("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, 32'(instr_ready), 32'd1);
    check_eq({tag, "_wen"}, 32'(wen), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_illegal"}, 32'(illegal), 32'd0);
    check_eq({tag, "_regs"}, {17'd0, rs1, rs2, rd}, 32'd0);
    check_eq({tag, "_funct"}, {22'd0, funct7, funct3}, 32'd0);
    check_eq({tag, "_aluop"}, 32'(aluOp), 32'(TYPE_R));
    check_eq({tag, "_count"}, 32'(retired_count), 32'd0);
  endtask

  // Output monitor: pops the scoreboard on every done/illegal pulse.
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_pend) begin
        mon_pend = 1'b0;
        check_eq("ready_after", 32'(instr_ready), 32'd1);
        check_eq("count", 32'(retired_count), pe.count);
        if (pe.is_done) check_eq("rd_value", regs[pe.rd], pe.value);
      end
      if (wen && !done) check_eq("wen_stray", 32'(wen), 32'd0);
      if (done || illegal) begin
        check_eq("done_illegal_excl", 32'(done & illegal), 32'd0);
        if (sb.size() == 0) begin
          check_eq("unexpected_pulse", {30'd0, done, illegal}, 32'd0);
        end else begin
          e = sb.pop_front();
          check_eq("kind", 32'(done), 32'(e.is_done));
          check_eq("latency", 32'(cyc - e.acc), 32'(e.lat));
          if (e.is_done) begin
            check_eq("wen", 32'(wen), 32'(e.rd != 5'd0));
            check_eq("rd", 32'(rd), 32'(e.rd));
          end
          pe = e;
          mon_pend = 1'b1;
        end
      end
    end
  end

  initial begin : stim
    int acc;
    int prev;
    #2 rstN = 1'b0;
    #1 check_reset_outputs("por");
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    for (int i = 0; i < 32; i++) preload(5'(i), 32'd0);
    preload(5'd10, 32'd5);
    preload(5'd11, 32'd7);

    send(32'h00B502B3, 1'b1, 5'd5, 32'd12, 2, 1'b0, acc);          // add x5
    drain();
    send(32'h40B502B3, 1'b1, 5'd5, 32'hFFFFFFFE, 2, 1'b0, acc);    // sub x5
    drain();
    preload(5'd7, 32'h80000000);
    preload(5'd8, 32'd4);
    send(32'h4083D333, 1'b1, 5'd6, 32'hF8000000, 2, 1'b0, acc);    // sra x6
    drain();
    send(32'h40B512B3, 1'b0, 5'd0, 32'd0, 0, 1'b0, acc);           // funct7 alt with funct3=1
    drain();
    send(32'h00A50293, 1'b0, 5'd0, 32'd0, 0, 1'b0, acc);           // addi
    drain();
    check_eq("x5_kept", regs[5], 32'hFFFFFFFE);

    // ALU error reported during execute rejects without writing
    err_inj = 1'b1;
    send(32'h00B502B3, 1'b0, 5'd0, 32'd0, 2, 1'b0, acc);
    drain();
    err_inj = 1'b0;
    check_eq("err_no_write", regs[5], 32'hFFFFFFFE);

    // Reset while the add sits in EXECUTE
    preload(5'd5, 32'hA5A5A5A5);
    send(32'h00B502B3, 1'b1, 5'd5, 32'd12, 2, 1'b0, acc);
    @(negedge clk);
    check_eq("busy_ready", 32'(instr_ready), 32'd0);
    check_eq("pre_rst_count", 32'(retired_count), 32'd3);
    rstN = 1'b0;
    sb.delete();
    exp_count = '0;
    #1 check_reset_outputs("mid");
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("mid_rst_no_write", regs[5], 32'hA5A5A5A5);

    send(32'h00B50033, 1'b1, 5'd0, 32'd0, 2, 1'b0, acc);           // add x0
    drain();

    // Counter wrap with instr_valid held high: 1,2,3,0,1
    rstN = 1'b0;
    exp_count = '0;
    @(negedge clk);
    rstN = 1'b1;
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      send(32'h00B502B3, 1'b1, 5'd5, 32'd12, 2, 1'b1, acc);
      if (i > 0) check_eq("b2b_spacing", 32'(acc - prev), 32'd4);
      prev = acc;
    end
    instr_valid = 1'b0;
    drain();
    check_eq("wrap_final", 32'(retired_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
